// File: rtl/fpga_pkg.sv
// Shared definitions for the fpga program-execution block and its post-run checker.
package fpga_pkg;

    localparam int MemoryElementWidth = 12;
    localparam int NArea              = 16;
    localparam int NArrays            = 2;
    localparam int NHeap              = 32;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        READ,
        COMPARE,
        DONE
    } checker_state_t;

    localparam logic KIND_HEAP = 1'b0;
    localparam logic KIND_SIZE = 1'b1;

endpackage

// File: rtl/heap_address_calc.sv
// Maps {array, index} to a heap word address and flags expectations that fall
// outside the configured array/area geometry. Purely combinational.
module heap_address_calc #(
    parameter int MemoryElementWidth = fpga_pkg::MemoryElementWidth,
    parameter int NArea              = fpga_pkg::NArea,
    parameter int NArrays            = fpga_pkg::NArrays,
    parameter int NHeap              = fpga_pkg::NHeap,
    localparam int AW                = $clog2(NHeap)
) (
    input  logic                          kind,
    input  logic [MemoryElementWidth-1:0] array,
    input  logic [MemoryElementWidth-1:0] index,
    output logic [AW-1:0]                 addr,
    output logic                          in_range
);

    // Wide enough that array*NArea+index never wraps before truncation.
    localparam int FW = 2 * MemoryElementWidth + 1;

    assign addr = AW'(FW'(array) * FW'(NArea) + FW'(index));

    // Length checks only need a valid array number; the index is don't-care.
    assign in_range = (array < MemoryElementWidth'(NArrays)) &&
                      ((kind == fpga_pkg::KIND_SIZE) ||
                       (index < MemoryElementWidth'(NArea)));

endmodule

// File: rtl/heap_result_checker.sv
// Post-run checker: compares a stream of expected heap elements / array lengths
// against the program's heap and size table, reporting pass, count and first failure.
module heap_result_checker #(
    parameter int MemoryElementWidth = fpga_pkg::MemoryElementWidth,
    parameter int NArea              = fpga_pkg::NArea,
    parameter int NArrays            = fpga_pkg::NArrays,
    parameter int NHeap              = fpga_pkg::NHeap,
    parameter int CountWidth         = 8,
    localparam int AW                = $clog2(NHeap),
    localparam int SW                = $clog2(NArrays)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            exp_valid,
    output logic                            exp_ready,
    input  logic                            exp_kind,
    input  logic [MemoryElementWidth-1:0]   exp_array,
    input  logic [MemoryElementWidth-1:0]   exp_index,
    input  logic [MemoryElementWidth-1:0]   exp_value,
    input  logic                            exp_last,
    output logic                            heap_rd_en,
    output logic [AW-1:0]                   heap_addr,
    input  logic [MemoryElementWidth-1:0]   heap_data,
    output logic                            size_rd_en,
    output logic [SW-1:0]                   size_addr,
    input  logic [MemoryElementWidth-1:0]   size_data,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [CountWidth-1:0]           mismatches,
    output logic [2*MemoryElementWidth-1:0] first_fail
);

    import fpga_pkg::checker_state_t;
    import fpga_pkg::IDLE;
    import fpga_pkg::ACCEPT;
    import fpga_pkg::READ;
    import fpga_pkg::COMPARE;
    import fpga_pkg::DONE;
    import fpga_pkg::KIND_HEAP;
    import fpga_pkg::KIND_SIZE;

    localparam int W = MemoryElementWidth;

    checker_state_t state, state_next;

    logic                  kind_q;
    logic                  last_q;
    logic [W-1:0]          arr_q;
    logic [W-1:0]          idx_q;
    logic [W-1:0]          val_q;
    logic [AW-1:0]         heap_addr_q;
    logic [SW-1:0]         size_addr_q;
    logic [CountWidth-1:0] mm_q;
    logic [2*W-1:0]        ff_q;

    logic [AW-1:0]         calc_addr;
    logic                  calc_in_range;

    logic                  handshake;
    logic                  arm;
    logic [W-1:0]          rd_data;
    logic                  record;
    logic                  rec_kind;
    logic [W-1:0]          rec_array;
    logic [W-1:0]          rec_index;

    heap_address_calc #(
        .MemoryElementWidth (MemoryElementWidth),
        .NArea              (NArea),
        .NArrays            (NArrays),
        .NHeap              (NHeap)
    ) u_addr (
        .kind     (exp_kind),
        .array    (exp_array),
        .index    (exp_index),
        .addr     (calc_addr),
        .in_range (calc_in_range)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        exp_ready  = 1'b0;
        heap_rd_en = 1'b0;
        size_rd_en = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = ACCEPT;
            end
            ACCEPT: begin
                exp_ready = 1'b1;
                busy      = 1'b1;
                if (exp_valid) begin
                    if (!calc_in_range) state_next = exp_last ? DONE : ACCEPT;
                    else                state_next = READ;
                end
            end
            READ: begin
                busy       = 1'b1;
                heap_rd_en = (kind_q == KIND_HEAP);
                size_rd_en = (kind_q == KIND_SIZE);
                state_next = COMPARE;
            end
            COMPARE: begin
                busy       = 1'b1;
                state_next = last_q ? DONE : ACCEPT;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = ACCEPT;
            end
            default: state_next = IDLE;
        endcase
    end

    assign handshake = exp_valid && (state == ACCEPT);
    assign arm       = start && ((state == IDLE) || (state == DONE));
    assign rd_data   = (kind_q == KIND_SIZE) ? size_data : heap_data;

    // A mismatch comes either from a rejected expectation at accept time or a
    // failed compare; the reported location follows whichever produced it.
    always_comb begin
        record    = 1'b0;
        rec_kind  = exp_kind;
        rec_array = exp_array;
        rec_index = exp_index;
        if (state == COMPARE) begin
            record    = (rd_data != val_q);
            rec_kind  = kind_q;
            rec_array = arr_q;
            rec_index = idx_q;
        end else if (handshake && !calc_in_range) begin
            record = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            kind_q      <= KIND_HEAP;
            last_q      <= 1'b0;
            arr_q       <= '0;
            idx_q       <= '0;
            val_q       <= '0;
            heap_addr_q <= '0;
            size_addr_q <= '0;
            mm_q        <= '0;
            ff_q        <= '1;
        end else begin
            if (arm) begin
                mm_q <= '0;
                ff_q <= '1;
            end
            if (handshake) begin
                kind_q      <= exp_kind;
                last_q      <= exp_last;
                arr_q       <= exp_array;
                idx_q       <= exp_index;
                val_q       <= exp_value;
                heap_addr_q <= calc_addr;
                size_addr_q <= SW'(exp_array);
            end
            if (record) begin
                if (mm_q == '0) begin
                    ff_q <= {rec_array, (rec_kind == KIND_SIZE) ? {W{1'b1}} : rec_index};
                end
                if (mm_q != '1) begin
                    mm_q <= mm_q + CountWidth'(1);
                end
            end
        end
    end

    assign heap_addr  = heap_addr_q;
    assign size_addr  = size_addr_q;
    assign mismatches = mm_q;
    assign first_fail = ff_q;
    assign pass       = done && (mm_q == '0);

endmodule

// File: tb/tb_heap_result_checker.sv
// Self-checking bench for heap_result_checker: directed scenarios plus randomized
// expectation streams checked against a queue-based reference model.
module tb_heap_result_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        exp_valid;
    logic        exp_ready;
    logic        exp_kind;
    logic [11:0] exp_array;
    logic [11:0] exp_index;
    logic [11:0] exp_value;
    logic        exp_last;
    logic        heap_rd_en;
    logic [4:0]  heap_addr;
    logic [11:0] heap_data;
    logic        size_rd_en;
    logic [0:0]  size_addr;
    logic [11:0] size_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  mismatches;
    logic [23:0] first_fail;

    typedef struct packed {
        logic        kind;
        logic [11:0] array;
        logic [11:0] index;
        logic [11:0] value;
    } exp_t;

    exp_t        q[$];
    logic [11:0] mem[32];
    logic [11:0] sizes[2];
    int          tests = 0;
    int          failed = 0;
    int          rd_total = 0;

    heap_result_checker #(
        .MemoryElementWidth (12),
        .NArea              (16),
        .NArrays            (2),
        .NHeap              (32),
        .CountWidth         (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .exp_valid  (exp_valid),
        .exp_ready  (exp_ready),
        .exp_kind   (exp_kind),
        .exp_array  (exp_array),
        .exp_index  (exp_index),
        .exp_value  (exp_value),
        .exp_last   (exp_last),
        .heap_rd_en (heap_rd_en),
        .heap_addr  (heap_addr),
        .heap_data  (heap_data),
        .size_rd_en (size_rd_en),
        .size_addr  (size_addr),
        .size_data  (size_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .mismatches (mismatches),
        .first_fail (first_fail)
    );

    always #5 clock = ~clock;

    // Synchronous read ports; garbage between reads exposes mistimed sampling.
    always @(posedge clock) begin
        heap_data <= heap_rd_en ? mem[heap_addr] : 12'($urandom);
        size_data <= size_rd_en ? sizes[size_addr] : 12'($urandom);
    end

    always @(negedge clock) begin
        rd_total <= rd_total + int'(heap_rd_en) + int'(size_rd_en);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: walk the expectation list applying the checking rules directly.
    function automatic void model(output int mm, output logic [23:0] ff,
                                  output int reads, output int cyc);
        mm = 0; ff = '1; reads = 0; cyc = 0;
        for (int i = 0; i < q.size(); i++) begin
            exp_t        e;
            logic        bad;
            logic [11:0] actual;
            e = q[i];
            if (e.array >= 2 || (e.kind == 1'b0 && e.index >= 16)) begin
                bad = 1'b1;
                cyc += 1;
            end else begin
                reads++;
                cyc += 3;
                actual = e.kind ? sizes[e.array] : mem[e.array * 16 + e.index];
                bad = (actual != e.value);
            end
            if (bad) begin
                if (mm == 0) ff = {e.array, e.kind ? 12'hfff : e.index};
                if (mm < 255) mm++;
            end
        end
    endfunction

    function automatic logic [11:0] truth(input exp_t e);
        if (e.array >= 2 || (e.kind == 1'b0 && e.index >= 16)) return 12'h0;
        return e.kind ? sizes[e.array] : mem[e.array * 16 + e.index];
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  exp_ready,  0);
        check({tag, "_hrd"},    heap_rd_en, 0);
        check({tag, "_srd"},    size_rd_en, 0);
        check({tag, "_busy"},   busy,       0);
        check({tag, "_done"},   done,       0);
        check({tag, "_pass"},   pass,       0);
        check({tag, "_mm"},     mismatches, 0);
        check({tag, "_ff"},     first_fail, 32'hffffff);
        check({tag, "_haddr"},  heap_addr,  0);
        check({tag, "_saddr"},  size_addr,  0);
    endtask

    task automatic run(input string tag, input bit gaps);
        int          em, er, ec, rd0, idx, cyc;
        logic [23:0] eff;
        bit          hs;
        model(em, eff, er, ec);
        rd0 = rd_total;
        @(negedge clock); start = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done_low"}, done, 0);
        idx = 0; cyc = 0;
        while (!done && cyc < 4000) begin
            if (idx < q.size()) begin
                exp_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                if (exp_valid) begin
                    {exp_kind, exp_array, exp_index, exp_value} = q[idx];
                    exp_last = (idx == q.size() - 1);
                end else begin
                    {exp_kind, exp_array, exp_index, exp_value} = 37'($urandom);
                    exp_last = 1'($urandom);
                end
            end else begin
                exp_valid = 1'b0;
            end
            // start while busy must not disturb the run
            start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            hs = exp_valid && exp_ready;
            @(posedge clock);
            cyc++;
            if (hs) idx++;
            @(negedge clock);
        end
        exp_valid = 1'b0;
        start = 1'b0;
        check({tag, "_done"},  done,       1);
        check({tag, "_taken"}, idx,        q.size());
        check({tag, "_mm"},    mismatches, em);
        check({tag, "_ff"},    first_fail, eff);
        check({tag, "_pass"},  pass,       (em == 0));
        check({tag, "_reads"}, rd_total - rd0, er);
        if (!gaps) check({tag, "_cycles"}, cyc, ec);
    endtask

    function automatic exp_t mk(input logic kind, input int a, input int i, input int v);
        exp_t e;
        e.kind = kind; e.array = 12'(a); e.index = 12'(i); e.value = 12'(v);
        return e;
    endfunction

    task automatic load_heap_ok();
        int a1[10] = '{100, 101, 4, 5, 6, 105, 106, 107, 108, 109};
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(mk(1'b0, 0, i, i));
        for (int i = 0; i < 10; i++) q.push_back(mk(1'b0, 1, i, a1[i]));
    endtask

    initial begin
        int a1[10] = '{100, 101, 4, 5, 6, 105, 106, 107, 108, 109};
        exp_t e;
        reset = 1'b1; start = 1'b0; exp_valid = 1'b0; exp_kind = 1'b0;
        exp_array = '0; exp_index = '0; exp_value = '0; exp_last = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 12'($urandom);
        for (int i = 0; i < 10; i++) begin
            mem[i] = 12'(i);
            mem[16 + i] = 12'(a1[i]);
        end
        sizes[0] = 12'd10; sizes[1] = 12'd10;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;

        load_heap_ok();
        run("heap_ok", 1'b0);
        check("heap_ok_pass_const", pass, 1);
        check("heap_ok_ff_const", first_fail, 32'hffffff);

        q.delete();
        q.push_back(mk(1'b1, 0, 0, 10));
        q.push_back(mk(1'b1, 1, 0, 10));
        run("len_ok", 1'b0);
        sizes[1] = 12'd9;
        run("len_bad", 1'b0);
        check("len_bad_ff_const", first_fail, 32'h001fff);
        sizes[1] = 12'd10;

        mem[19] = 12'd103;
        q.delete();
        q.push_back(mk(1'b0, 1, 3, 5));
        run("heap_bad1", 1'b0);
        check("heap_bad1_ff_const", first_fail, 32'h001003);
        mem[23] = 12'd0;
        q.push_back(mk(1'b0, 1, 7, 107));
        run("heap_bad2", 1'b0);
        check("heap_bad2_mm_const", mismatches, 2);
        mem[19] = 12'd5; mem[23] = 12'd107;

        q.delete();
        q.push_back(mk(1'b0, 2, 0, 0));
        q.push_back(mk(1'b0, 0, 16, 0));
        run("oor", 1'b0);
        check("oor_ff_const", first_fail, 32'h002000);

        q.delete();
        for (int i = 0; i < 300; i++) begin
            e = mk(1'b0, $urandom_range(0, 1), $urandom_range(0, 15), 0);
            e.value = truth(e) + 12'd1;
            q.push_back(e);
        end
        run("saturate", 1'b1);
        check("saturate_mm_const", mismatches, 255);

        for (int r = 0; r < 6; r++) begin
            q.delete();
            for (int i = 0; i < $urandom_range(10, 30); i++) begin
                int s;
                s = $urandom_range(0, 9);
                e.kind  = (s < 3);
                e.array = (s == 9) ? 12'($urandom_range(2, 4095)) : 12'($urandom_range(0, 1));
                e.index = (s == 8 && !e.kind) ? 12'($urandom_range(16, 4095))
                                              : 12'($urandom_range(0, 15));
                e.value = $urandom_range(0, 1) ? truth(e) : 12'($urandom);
                q.push_back(e);
            end
            run($sformatf("rand%0d", r), r[0]);
        end

        // Reset while the checker sits in COMPARE, then a clean rerun.
        @(negedge clock);
        start = 1'b1;
        {exp_kind, exp_array, exp_index, exp_value} = mk(1'b0, 0, 5, 7);
        exp_last = 1'b1; exp_valid = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        @(posedge clock);
        @(negedge clock); exp_valid = 1'b0;
        check("rst_mid_read", heap_rd_en, 1);
        @(posedge clock);
        @(negedge clock);
        check("rst_mid_busy", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_vals("rst_mid");
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst_after_hrd", heap_rd_en, 0);
        check("rst_after_done", done, 0);
        load_heap_ok();
        run("rerun", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
